// File: rtl/gsensor_spi_sequencer.sv
// Configures an ADXL345-style accelerometer through a byte-wide SPI primary, then polls X/Y/Z
// on a fixed period and publishes samples atomically. GSENSOR_SEQ_ID_CHECK_EN adds a DEVID check.
module gsensor_spi_sequencer #(
    parameter int POLL_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    output logic               txn_start,
    output logic               txn_rw,
    output logic [5:0]         txn_addr,
    output logic [7:0]         txn_wdata,
    input  logic               txn_busy,
    input  logic               txn_done,
    input  logic [7:0]         txn_rdata,
    output logic signed [15:0] accel_x,
    output logic signed [15:0] accel_y,
    output logic signed [15:0] accel_z,
    output logic               data_valid,
    output logic               init_done,
    output logic               init_error
);
    localparam int CW = $clog2(POLL_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(POLL_CYCLES - 1);

    localparam logic [2:0] ST_RESET_WAIT = 3'd0;
    localparam logic [2:0] ST_INIT       = 3'd2;
    localparam logic [2:0] ST_WAIT       = 3'd3;
    localparam logic [2:0] ST_POLL       = 3'd4;
    localparam logic [2:0] ST_PUBLISH    = 3'd5;
`ifdef GSENSOR_SEQ_ID_CHECK_EN
    localparam logic [2:0] ST_ID_CHECK   = 3'd1;
    localparam logic [2:0] ST_ERROR      = 3'd6;
`endif

    logic [2:0]      state;
    logic            issue;     // 1 = ISSUE sub-state, 0 = WAIT_DONE
    logic [2:0]      idx;
    logic [CW-1:0]   cnt;
    logic [4:0][7:0] shadow;    // b0..b4; b5 is taken straight off txn_rdata at publish
    logic            txn_fin;

    assign txn_start = issue && !txn_busy;
    assign txn_fin   = !issue && txn_done;

    function automatic logic [13:0] init_entry(input logic [2:0] i);
        case (i)
            3'd0:    return {6'h2C, 8'h0A};
            3'd1:    return {6'h31, 8'h08};
            default: return {6'h2D, 8'h08};
        endcase
    endfunction

`ifndef GSENSOR_SEQ_ID_CHECK_EN
    assign init_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_RESET_WAIT;
            issue      <= 1'b0;
            idx        <= 3'd0;
            cnt        <= '0;
            shadow     <= '0;
            txn_rw     <= 1'b0;
            txn_addr   <= 6'h00;
            txn_wdata  <= 8'h00;
            accel_x    <= '0;
            accel_y    <= '0;
            accel_z    <= '0;
            data_valid <= 1'b0;
            init_done  <= 1'b0;
`ifdef GSENSOR_SEQ_ID_CHECK_EN
            init_error <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            if (issue && !txn_busy)
                issue <= 1'b0;

            // Period counter runs through the burst and saturates, so a late burst restarts at once
            if (state == ST_WAIT || state == ST_POLL || state == ST_PUBLISH) begin
                if (state == ST_WAIT && cnt == CNT_LAST && enable)
                    cnt <= '0;
                else if (cnt != CNT_LAST)
                    cnt <= cnt + CW'(1);
            end

            case (state)
                ST_RESET_WAIT: begin
                    issue <= 1'b1;
                    idx   <= 3'd0;
`ifdef GSENSOR_SEQ_ID_CHECK_EN
                    state     <= ST_ID_CHECK;
                    txn_rw    <= 1'b1;
                    txn_addr  <= 6'h00;
                    txn_wdata <= 8'h00;
`else
                    state                 <= ST_INIT;
                    txn_rw                <= 1'b0;
                    {txn_addr, txn_wdata} <= init_entry(3'd0);
`endif
                end
`ifdef GSENSOR_SEQ_ID_CHECK_EN
                ST_ID_CHECK: if (txn_fin) begin
                    if (txn_rdata == 8'hE5) begin
                        state                 <= ST_INIT;
                        issue                 <= 1'b1;
                        idx                   <= 3'd0;
                        txn_rw                <= 1'b0;
                        {txn_addr, txn_wdata} <= init_entry(3'd0);
                    end else begin
                        state      <= ST_ERROR;
                        init_error <= 1'b1;
                    end
                end
                ST_ERROR: state <= ST_ERROR;
`endif
                ST_INIT: if (txn_fin) begin
                    if (idx == 3'd2) begin
                        init_done <= 1'b1;
                        state     <= ST_WAIT;
                    end else begin
                        idx                   <= idx + 3'd1;
                        {txn_addr, txn_wdata} <= init_entry(idx + 3'd1);
                        issue                 <= 1'b1;
                    end
                end
                ST_WAIT: if (cnt == CNT_LAST && enable) begin
                    state     <= ST_POLL;
                    issue     <= 1'b1;
                    idx       <= 3'd0;
                    txn_rw    <= 1'b1;
                    txn_addr  <= 6'h32;
                    txn_wdata <= 8'h00;
                end
                ST_POLL: if (txn_fin) begin
                    if (idx == 3'd5) begin
                        accel_x    <= {shadow[1], shadow[0]};
                        accel_y    <= {shadow[3], shadow[2]};
                        accel_z    <= {txn_rdata, shadow[4]};
                        data_valid <= 1'b1;
                        state      <= ST_PUBLISH;
                    end else begin
                        shadow   <= {txn_rdata, shadow[4:1]};
                        idx      <= idx + 3'd1;
                        txn_addr <= txn_addr + 6'd1;
                        issue    <= 1'b1;
                    end
                end
                ST_PUBLISH: state <= ST_WAIT;
                default:    state <= ST_RESET_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_gsensor_spi_sequencer.sv
// Bench for gsensor_spi_sequencer: SPI primary mimic with random latency, table and random bursts
// checked against an arithmetic sample model, plus busy-hold, enable-drop and mid-burst reset cases.
`timescale 1ns/1ps
module tb_gsensor_spi_sequencer;
    localparam int P = 2000;

    logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
    logic txn_start, txn_rw, txn_busy, txn_done, data_valid, init_done, init_error;
    logic [5:0] txn_addr;
    logic [7:0] txn_wdata, txn_rdata;
    logic signed [15:0] accel_x, accel_y, accel_z;

    gsensor_spi_sequencer #(.POLL_CYCLES(P)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .txn_start(txn_start), .txn_rw(txn_rw), .txn_addr(txn_addr), .txn_wdata(txn_wdata),
        .txn_busy(txn_busy), .txn_done(txn_done), .txn_rdata(txn_rdata),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
        .data_valid(data_valid), .init_done(init_done), .init_error(init_error)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI primary mimic
    logic [47:0] rd_bytes = '0;
    logic [7:0]  devid = 8'hE5;
    int hold_req = 0, lat = 0, hold = 0;
    logic active = 1'b0;

    function automatic logic [7:0] mimic_rd(input logic [5:0] a);
        if (a == 6'h00) return devid;
        if (a >= 6'h32 && a <= 6'h37) return rd_bytes[(int'(a) - 50) * 8 +: 8];
        return 8'h00;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txn_busy <= 1'b0; txn_done <= 1'b0; txn_rdata <= 8'h00;
            active <= 1'b0; lat <= 0; hold <= 0;
        end else begin
            txn_done <= 1'b0;
            if (txn_start) begin
                active <= 1'b1; txn_busy <= 1'b1; lat <= int'($urandom_range(5, 2));
            end else if (active) begin
                if (lat == 0) begin
                    active <= 1'b0; txn_done <= 1'b1; txn_rdata <= mimic_rd(txn_addr);
                    txn_busy <= (hold_req != 0); hold <= hold_req;
                end else lat <= lat - 1;
            end else if (hold != 0) begin
                hold <= hold - 1;
                if (hold == 1) txn_busy <= 1'b0;
            end
        end
    end

    // Monitor: everything observed is logged with its cycle number
    logic [14:0] txlog [$];
    int start_cyc [$], done_cyc [$], dv_cyc [$];
    logic [47:0] dv_val [$];
    logic [47:0] last_acc = '0;
    int partial = 0, proto_err = 0, initdone_cyc = -1;

    always @(negedge clk) begin
        if (txn_start) begin
            txlog.push_back({txn_rw, txn_addr, txn_wdata});
            start_cyc.push_back(cyc);
            if (txn_busy) proto_err++;
        end
        if (txn_done) done_cyc.push_back(cyc);
        if (data_valid) begin
            dv_cyc.push_back(cyc);
            dv_val.push_back({accel_x, accel_y, accel_z});
        end else if (reset_n && {accel_x, accel_y, accel_z} != last_acc) partial++;
        last_acc = {accel_x, accel_y, accel_z};
        if (!reset_n) initdone_cyc = -1;
        else if (init_done && initdone_cyc < 0) initdone_cyc = cyc;
    end

    typedef struct packed {
        logic [47:0] bytes;
        logic [15:0] x, y, z;
    } vec_t;
    vec_t tbl [3];
    logic [14:0] exp_init [$];
    int bt_base, bdv_base;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] model_acc(input logic [47:0] by);
        int v [3];
        for (int a = 0; a < 3; a++) v[a] = int'(by[16*a+8 +: 8]) * 256 + int'(by[16*a +: 8]);
        return {16'(v[0]), 16'(v[1]), 16'(v[2])};
    endfunction

    task automatic run_init();
        int tb0, db0, n;
        tb0 = txlog.size(); db0 = done_cyc.size(); n = 0;
        reset_n = 1'b1;
        while (!init_done && n < 1000) begin tick(); n++; end
        tick();
        check("init_done_seen", init_done, 1);
        check("init_error_low", init_error, 0);
        check("init_count", txlog.size() - tb0, exp_init.size());
        for (int i = 0; i < exp_init.size() && tb0 + i < txlog.size(); i++) begin
            check("init_txn", txlog[tb0+i], exp_init[i]);
            if (i > 0 && db0 + i - 1 < done_cyc.size())
                check("start_after_done", start_cyc[tb0+i], done_cyc[db0+i-1] + 1);
        end
        if (done_cyc.size() > 0)
            check("init_done_latency", initdone_cyc, done_cyc[done_cyc.size()-1] + 1);
    endtask

    task automatic begin_burst(input logic [47:0] by);
        rd_bytes = by; bt_base = txlog.size(); bdv_base = dv_cyc.size();
    endtask

    task automatic finish_burst(input logic [47:0] exp_acc, output int bstart);
        int n;
        n = 0; bstart = -1;
        while (dv_cyc.size() <= bdv_base && n < 3*P) begin tick(); n++; end
        if (dv_cyc.size() <= bdv_base) begin
            check("burst_timeout", 0, 1);
            return;
        end
        check("burst_reads", txlog.size() - bt_base, 6);
        for (int k = 0; k < 6 && bt_base + k < txlog.size(); k++)
            check("burst_txn", txlog[bt_base+k], {1'b1, 6'(6'h32 + k), 8'h00});
        check("burst_accel", dv_val[bdv_base], exp_acc);
        check("dv_latency", dv_cyc[bdv_base], done_cyc[done_cyc.size()-1] + 1);
        bstart = start_cyc[bt_base];
    endtask

    task automatic wait_start(input logic [5:0] a);
        bit ok;
        ok = 0;
        for (int n = 0; n < 3*P && !ok; n++) begin
            tick();
            if (txn_start && txn_addr == a) ok = 1;
        end
        check("wait_start", ok, 1);
    endtask

    initial begin
        logic [47:0] by;
        int bs, prev_bs, nd, ns, n;
        tbl[0] = '{bytes: 48'h8000_FFFF_1234, x: 16'h1234, y: 16'hFFFF, z: 16'h8000};
        tbl[1] = '{bytes: 48'h0001_7FFF_0000, x: 16'h0000, y: 16'h7FFF, z: 16'h0001};
        tbl[2] = '{bytes: 48'hA55A_0080_CDAB, x: 16'hCDAB, y: 16'h0080, z: 16'hA55A};
`ifdef GSENSOR_SEQ_ID_CHECK_EN
        exp_init.push_back({1'b1, 6'h00, 8'h00});
`endif
        exp_init.push_back({1'b0, 6'h2C, 8'h0A});
        exp_init.push_back({1'b0, 6'h31, 8'h08});
        exp_init.push_back({1'b0, 6'h2D, 8'h08});

        repeat (3) tick();
        check("reset_txn", {txn_start, txn_rw, txn_addr, txn_wdata}, 0);
        check("reset_accel", {accel_x, accel_y, accel_z}, 0);
        check("reset_flags", {data_valid, init_done, init_error}, 0);
        run_init();

        // Table bursts then random bursts, back to back with enable high
        prev_bs = -1;
        for (int i = 0; i < 3; i++) begin
            begin_burst(tbl[i].bytes);
            enable = 1'b1;
            finish_burst({tbl[i].x, tbl[i].y, tbl[i].z}, bs);
            if (prev_bs >= 0 && bs >= 0) check("burst_period", bs - prev_bs, P);
            prev_bs = bs;
        end
        for (int i = 0; i < 5; i++) begin
            by = {16'($urandom), 32'($urandom)};
            begin_burst(by);
            finish_burst(model_acc(by), bs);
            if (prev_bs >= 0 && bs >= 0) check("burst_period", bs - prev_bs, P);
            prev_bs = bs;
        end

        // Busy held 50 cycles after the 0x33 read completes
        by = {16'($urandom), 32'($urandom)};
        begin_burst(by);
        wait_start(6'h33);
        nd = done_cyc.size(); hold_req = 50; n = 0;
        while (done_cyc.size() <= nd && n < 100) begin tick(); n++; end
        hold_req = 0;
        ns = start_cyc.size(); n = 0;
        while (start_cyc.size() <= ns && n < 200) begin tick(); n++; end
        if (start_cyc.size() > ns && done_cyc.size() > nd)
            check("busy_hold_gap", start_cyc[ns] - done_cyc[nd], 50);
        else
            check("busy_hold_timeout", 0, 1);
        finish_burst(model_acc(by), bs);

        // Enable dropped during the third read
        by = {16'($urandom), 32'($urandom)};
        begin_burst(by);
        wait_start(6'h34);
        enable = 1'b0;
        finish_burst(model_acc(by), bs);
        ns = start_cyc.size();
        repeat (2*P) tick();
        check("no_burst_disabled", start_cyc.size() - ns, 0);
        by = {16'($urandom), 32'($urandom)};
        begin_burst(by);
        enable = 1'b1;
        tick();
        check("restart_start", {txn_start, txn_addr}, {1'b1, 6'h32});
        finish_burst(model_acc(by), bs);

        // Reset during the fourth read
        begin_burst({16'($urandom), 32'($urandom)});
        wait_start(6'h35);
        tick();
        reset_n = 1'b0; #1;
        check("rst_txn", {txn_start, txn_rw, txn_addr, txn_wdata}, 0);
        check("rst_accel", {accel_x, accel_y, accel_z}, 0);
        check("rst_flags", {data_valid, init_done, init_error}, 0);
        repeat (3) tick();
        run_init();

`ifdef GSENSOR_SEQ_ID_CHECK_EN
        reset_n = 1'b0; devid = 8'h00;
        repeat (3) tick();
        ns = start_cyc.size();
        reset_n = 1'b1;
        repeat (10000) tick();
        check("id_error", init_error, 1);
        check("id_init_done", init_done, 0);
        check("id_starts", start_cyc.size() - ns, 1);
`endif

        check("protocol_busy", proto_err, 0);
        check("atomic_publish", partial, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
